// File: rtl/state_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : state_accum_pkg
// Description : Shared types and default sizes for the multi-channel
//               state accumulator (operation encoding, default W / CH).
// Revision    : 1.0 - initial release
// ============================================================================
package state_accum_pkg;

    // Default accumulator/data width and channel count
    localparam int DEF_W  = 8;
    localparam int DEF_CH = 4;

    // Operation applied to the target channel on a beat
    typedef enum logic [1:0] {
        MODE_XOR  = 2'd0,
        MODE_ADD  = 2'd1,
        MODE_OR   = 2'd2,
        MODE_LOAD = 2'd3
    } mode_e;

endpackage
`default_nettype wire

// File: rtl/state_accum_alu.sv
`default_nettype none
// ============================================================================
// Module      : state_accum_alu
// Description : Combinational operator: result = op(mode, s, d).
//               ADD wraps modulo 2^W (carry dropped).
// Revision    : 1.0 - initial release
// ============================================================================
module state_accum_alu
    import state_accum_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  mode_e          mode,
    input  logic [W-1:0]   s,
    input  logic [W-1:0]   d,
    output logic [W-1:0]   result
);

    // Select the operation; the W-bit sum truncates the carry naturally
    always_comb begin
        result = d;
        unique case (mode)
            MODE_XOR:  result = s ^ d;
            MODE_ADD:  result = s + d;
            MODE_OR:   result = s | d;
            MODE_LOAD: result = d;
            default:   result = d;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/state_accum.sv
`default_nettype none
// ============================================================================
// Module      : state_accum
// Description : CH independent W-bit accumulator channels. One beat per
//               cycle updates the addressed channel; the pre-update value
//               and the post-update parity are reported one cycle later.
//               rst is synchronous and active-low; clr zeroes all channels.
// Revision    : 1.0 - initial release
// ============================================================================
module state_accum
    import state_accum_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int CH  = DEF_CH,
    parameter int CHW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [CHW-1:0]  in_ch,
    input  logic [1:0]      in_mode,
    input  logic [W-1:0]    in_data,
    input  logic            clr,
    output logic            out_valid,
    output logic [CHW-1:0]  out_ch,
    output logic [W-1:0]    out_data,
    output logic            out_parity
);

    // Channel count widened by one bit so that the range test covers every
    // encodable index, including those at or above CH.
    localparam logic [CHW:0] CH_L = (CHW+1)'(CH);

    // Channel state and output registers
    logic [W-1:0]   ch_q [CH];
    logic [W-1:0]   ch_d [CH];
    logic           out_valid_q,  out_valid_d;
    logic [CHW-1:0] out_ch_q,     out_ch_d;
    logic [W-1:0]   out_data_q,   out_data_d;
    logic           out_parity_q, out_parity_d;

    // Datapath nets
    logic           hit;        // valid beat addressed to an existing channel
    logic [W-1:0]   cur_s;      // pre-update (pre-clear) value of target
    logic [W-1:0]   alu_s;      // operand seen by the ALU (0 when clearing)
    logic [W-1:0]   alu_result;

    assign hit = in_valid && ({1'b0, in_ch} < CH_L);

    // Read the addressed channel; out-of-range indices read as zero
    always_comb begin
        cur_s = '0;
        for (int i = 0; i < CH; i++) begin
            if (in_ch == i[CHW-1:0]) begin
                cur_s = ch_q[i];
            end
        end
    end

    // A simultaneous clear makes the target start from zero: op(0, d)
    assign alu_s = clr ? '0 : cur_s;

    state_accum_alu #(
        .W (W)
    ) u_alu (
        .mode   (mode_e'(in_mode)),
        .s      (alu_s),
        .d      (in_data),
        .result (alu_result)
    );

    // Next channel state: clear everything, then overlay the target result
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            ch_d[i] = clr ? '0 : ch_q[i];
            if (hit && (in_ch == i[CHW-1:0])) begin
                ch_d[i] = alu_result;
            end
        end
    end

    // Next output values: report on every valid beat, hold otherwise
    always_comb begin
        out_valid_d  = in_valid;
        out_ch_d     = out_ch_q;
        out_data_d   = out_data_q;
        out_parity_d = out_parity_q;
        if (in_valid) begin
            out_ch_d     = in_ch;
            out_data_d   = hit ? cur_s : '0;
            out_parity_d = hit ? ^alu_result : 1'b0;
        end
    end

    // State and output registers; reset overrides clr and any beat
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CH; i++) begin
                ch_q[i] <= '0;
            end
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_data_q   <= '0;
            out_parity_q <= 1'b0;
        end else begin
            ch_q         <= ch_d;
            out_valid_q  <= out_valid_d;
            out_ch_q     <= out_ch_d;
            out_data_q   <= out_data_d;
            out_parity_q <= out_parity_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign out_data   = out_data_q;
    assign out_parity = out_parity_q;

endmodule
`default_nettype wire

// File: tb/tb_state_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_state_accum
// Description : Self-checking bench for state_accum (W=8, CH=4, CHW=3):
//               directed vector table followed by random traffic compared
//               against a behavioural model of the channel array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_state_accum;

    localparam int W   = 8;
    localparam int CH  = 4;
    localparam int CHW = 3;

    localparam int XR = 0;
    localparam int AD = 1;
    localparam int OR_ = 2;
    localparam int LD = 3;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [CHW-1:0] in_ch;
    logic [1:0]     in_mode;
    logic [W-1:0]   in_data;
    logic           clr;
    logic           out_valid;
    logic [CHW-1:0] out_ch;
    logic [W-1:0]   out_data;
    logic           out_parity;

    state_accum #(
        .W   (W),
        .CH  (CH),
        .CHW (CHW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ch      (in_ch),
        .in_mode    (in_mode),
        .in_data    (in_data),
        .clr        (clr),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .out_data   (out_data),
        .out_parity (out_parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           r;
        bit           v;
        bit [CHW-1:0] ch;
        bit [1:0]     mode;
        bit [W-1:0]   data;
        bit           c;
        bit           ev;
        bit [CHW-1:0] ech;
        bit [W-1:0]   ed;
        bit           ep;
    } vec_t;

    vec_t tbl[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: plain integer channel values and expected outputs
    int m[CH];
    int m_valid = 0, m_ch = 0, m_data = 0, m_par = 0;

    function automatic vec_t mk(bit r, bit v, int ch, int mode, int data, bit c,
                                bit ev, int ech, int ed, bit ep);
        vec_t t;
        t.r = r; t.v = v; t.ch = CHW'(ch); t.mode = 2'(mode);
        t.data = W'(data); t.c = c;
        t.ev = ev; t.ech = CHW'(ech); t.ed = W'(ed); t.ep = ep;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_step(input bit r, input bit v, input int ch, input int mode,
                              input int data, input bit c);
        int old_v, base, nv;
        if (!r) begin
            for (int i = 0; i < CH; i++) m[i] = 0;
            m_valid = 0; m_ch = 0; m_data = 0; m_par = 0;
            return;
        end
        m_valid = v ? 1 : 0;
        nv = 0;
        if (v) begin
            m_ch = ch;
            if (ch < CH) begin
                old_v = m[ch];
                base  = c ? 0 : old_v;
                case (mode)
                    XR:      nv = base ^ data;
                    AD:      nv = (base + data) % 256;
                    OR_:     nv = base | data;
                    default: nv = data;
                endcase
                m_data = old_v;
                m_par  = $countones(nv) % 2;
            end else begin
                m_data = 0;
                m_par  = 0;
            end
        end
        if (c) for (int i = 0; i < CH; i++) m[i] = 0;
        if (v && ch < CH) m[ch] = nv;
    endtask

    task automatic drive_cycle(input bit r, input bit v, input int ch, input int mode,
                               input int data, input bit c);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in_ch    = CHW'(ch);
        in_mode  = 2'(mode);
        in_data  = W'(data);
        clr      = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_ch = '0; in_mode = '0; in_data = '0; clr = 1'b0;
        for (int i = 0; i < CH; i++) m[i] = 0;

        //            r v ch mode data c   ev ech ed  ep
        // Reset state, and a beat during reset is discarded
        tbl.push_back(mk(0,0,0,XR, 8'h00,0, 0,0,8'h00,0));
        tbl.push_back(mk(0,1,1,LD, 8'hFF,0, 0,0,8'h00,0));
        // XOR chain on ch0
        tbl.push_back(mk(1,1,0,XR, 8'h01,0, 1,0,8'h00,1));
        tbl.push_back(mk(1,1,0,XR, 8'h01,0, 1,0,8'h01,0));
        tbl.push_back(mk(1,1,0,XR, 8'h03,0, 1,0,8'h00,0));
        tbl.push_back(mk(1,1,0,XR, 8'h00,0, 1,0,8'h03,0));
        // LOAD / ADD with wrap on ch1
        tbl.push_back(mk(1,1,1,LD, 8'hF0,0, 1,1,8'h00,0));
        tbl.push_back(mk(1,1,1,AD, 8'h20,0, 1,1,8'hF0,1));
        tbl.push_back(mk(1,1,1,AD, 8'h00,0, 1,1,8'h10,1));
        // Interleaved OR on ch2/ch3
        tbl.push_back(mk(1,1,2,OR_,8'h0F,0, 1,2,8'h00,0));
        tbl.push_back(mk(1,1,3,OR_,8'hF0,0, 1,3,8'h00,0));
        tbl.push_back(mk(1,1,2,OR_,8'h30,0, 1,2,8'h0F,0));
        tbl.push_back(mk(1,1,2,XR, 8'h00,0, 1,2,8'h3F,0));
        tbl.push_back(mk(1,1,3,XR, 8'h00,0, 1,3,8'hF0,0));
        // Idle holds last outputs
        tbl.push_back(mk(1,0,0,LD, 8'h99,0, 0,3,8'hF0,0));
        // clr together with a beat
        tbl.push_back(mk(1,1,0,LD, 8'hAA,0, 1,0,8'h03,0));
        tbl.push_back(mk(1,1,1,LD, 8'h11,0, 1,1,8'h10,0));
        tbl.push_back(mk(1,1,0,XR, 8'h55,1, 1,0,8'hAA,0));
        tbl.push_back(mk(1,1,1,XR, 8'h00,0, 1,1,8'h00,0));
        tbl.push_back(mk(1,1,0,XR, 8'h00,0, 1,0,8'h55,0));
        tbl.push_back(mk(1,1,2,XR, 8'h00,0, 1,2,8'h00,0));
        tbl.push_back(mk(1,1,3,XR, 8'h00,0, 1,3,8'h00,0));
        // Out-of-range channel
        tbl.push_back(mk(1,1,5,LD, 8'h77,0, 1,5,8'h00,0));
        tbl.push_back(mk(1,0,0,XR, 8'h00,0, 0,5,8'h00,0));
        tbl.push_back(mk(1,1,0,XR, 8'h00,0, 1,0,8'h55,0));
        tbl.push_back(mk(1,1,1,XR, 8'h00,0, 1,1,8'h00,0));
        // clr alone
        tbl.push_back(mk(1,0,0,XR, 8'h00,1, 0,1,8'h00,0));
        tbl.push_back(mk(1,1,0,XR, 8'h00,0, 1,0,8'h00,0));
        // Reset mid-stream discards the beat; next beat processed normally
        tbl.push_back(mk(1,1,2,LD, 8'h5B,0, 1,2,8'h00,1));
        tbl.push_back(mk(0,1,2,AD, 8'h01,0, 0,0,8'h00,0));
        tbl.push_back(mk(1,1,2,XR, 8'h00,0, 1,2,8'h00,0));

        foreach (tbl[k]) begin
            drive_cycle(tbl[k].r, tbl[k].v, int'(tbl[k].ch), int'(tbl[k].mode),
                        int'(tbl[k].data), tbl[k].c);
            model_step(tbl[k].r, tbl[k].v, int'(tbl[k].ch), int'(tbl[k].mode),
                       int'(tbl[k].data), tbl[k].c);
            check($sformatf("vec%0d out_valid", k), 32'(out_valid),  32'(tbl[k].ev));
            check($sformatf("vec%0d out_ch", k),    32'(out_ch),     32'(tbl[k].ech));
            check($sformatf("vec%0d out_data", k),  32'(out_data),   32'(tbl[k].ed));
            check($sformatf("vec%0d out_parity", k),32'(out_parity), 32'(tbl[k].ep));
        end

        // Random traffic against the model, including invalid channels,
        // simultaneous clears and occasional mid-stream resets
        for (int n = 0; n < 400; n++) begin
            bit r, v, c;
            int ch, mode, data;
            r    = ($urandom_range(0, 49) != 0);
            v    = ($urandom_range(0, 3) != 0);
            c    = ($urandom_range(0, 15) == 0);
            ch   = int'($urandom_range(0, 7));
            mode = int'($urandom_range(0, 3));
            data = int'($urandom_range(0, 255));
            drive_cycle(r, v, ch, mode, data, c);
            model_step(r, v, ch, mode, data, c);
            check($sformatf("rnd%0d out_valid", n), 32'(out_valid),  32'(m_valid));
            check($sformatf("rnd%0d out_ch", n),    32'(out_ch),     32'(m_ch));
            check($sformatf("rnd%0d out_data", n),  32'(out_data),   32'(m_data));
            check($sformatf("rnd%0d out_parity", n),32'(out_parity), 32'(m_par));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/state_accum.md
STATE_ACCUM -- requirements
Module: state_accum

Interface
REQ-001 Parameter W, default 8: accumulator and data width in bits (W >= 1).
REQ-002 Parameter CH, default 4: number of independent accumulator channels (CH >= 1).
REQ-003 Parameter CHW, default max(1, clog2(CH)): channel index width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  input beat present this cycle.
REQ-007 in_ch  in  CHW  target channel index.
REQ-008 in_mode  in  2  operation: 0 XOR, 1 ADD, 2 OR, 3 LOAD.
REQ-009 in_data  in  W  operand.
REQ-010 clr  in  1  clear all channels to zero.
REQ-011 out_valid  out  1  registered; 1 in the cycle after an accepted beat.
REQ-012 out_ch  out  CHW  channel of the reported beat.
REQ-013 out_data  out  W  channel value before the reported beat was applied.
REQ-014 out_parity  out  1  XOR-reduction of the channel value after the reported beat was applied.

Function
REQ-015 Each channel SHALL hold a W-bit state register; all channels are independent.
REQ-016 On a beat (in_valid=1, in_ch<CH), the next state of channel in_ch SHALL be: XOR -> s^d; ADD -> (s+d) mod 2^W, carry discarded; OR -> s|d; LOAD -> d.
REQ-017 The module SHALL accept one beat per cycle; there is no backpressure.
REQ-018 Latency SHALL be 1 cycle: out_valid, out_ch, out_data and out_parity appear in the cycle after the beat.
REQ-019 out_data SHALL equal the pre-update value of channel in_ch.
REQ-020 A beat with in_ch>=CH SHALL update no state, SHALL produce out_valid=1 with out_data=0 and out_parity=0, and SHALL report out_ch=in_ch.
REQ-021 With in_valid=0, state SHALL be unchanged, out_valid SHALL be 0, and out_ch/out_data/out_parity SHALL hold their last values.
REQ-022 clr=1 SHALL zero every channel at the edge.
REQ-023 When clr and a beat occur in the same cycle, non-target channels SHALL become 0, the target channel SHALL become op(0,d), and out_data SHALL still report the pre-clear value.
REQ-024 Back-to-back beats to the same channel SHALL chain: the second beat SHALL see the first beat's result with no bubble or hazard.

Reset
REQ-025 rst=0 at a rising edge SHALL set all channel states, out_valid, out_ch, out_data and out_parity to 0.
REQ-026 Reset SHALL take priority over clr and over any beat in the same cycle; that beat is discarded and produces no output.
REQ-027 After rst returns high, the first beat SHALL be processed normally on the next edge.

Structure
REQ-028 A shared package state_accum_pkg SHALL define the mode enumeration (XOR, ADD, OR, LOAD) and the default W/CH constants.
REQ-029 A combinational sub-module state_accum_alu(mode, s, d) -> result SHALL implement REQ-016.
REQ-030 The top level SHALL contain the channel register array, the output registers and the clr/reset control.

Verification (W=8, CH=4)
REQ-031 After reset, XOR beats to ch0 with 0x01, 0x01, 0x03 -> out_data 0x00, 0x01, 0x00; ch0 ends at 0x03; out_parity 1, 0, 0.
REQ-032 On ch1, LOAD 0xF0 then ADD 0x20 then ADD 0x00 -> out_data 0x00, 0xF0, 0x10 (wrap-around, carry discarded).
REQ-033 Interleave OR beats ch2 0x0F, ch3 0xF0, ch2 0x30 -> out_data 0x00, 0x00, 0x0F; ch2=0x3F and ch3=0xF0 (channel isolation).
REQ-034 With ch0=0xAA and ch1=0x11, assert clr together with XOR ch0 0x55 -> out_data 0xAA; ch0=0x55 and ch1=0x00 afterwards.
REQ-035 A beat to in_ch=5 (CH=4, CHW=3) -> out_valid=1, out_data=0x00, out_ch=5, no state change.
REQ-036 Drive rst=0 in the same cycle as a valid beat mid-stream -> next cycle out_valid=0 and all outputs and channels 0; no output is produced for the discarded beat.
